// File: rtl/param_updown_counter_if.sv
// Purpose: control/status bundle for param_updown_counter (one stage of a cascadable counter).
// Latency: carries no state; count/ovf/halted are registered in the counter, tc/c_out are combinational.
// Backpressure: none; enable is a per-cycle step strobe with no ready return path.
//
// Ports (all in the bundle, clk/reset stay on the counter itself):
//   load, load_in   parallel load strobe and value (clamped to MAX_VALUE inside the counter)
//   enable          step enable, or the c_out of the next-lower stage when cascading
//   up_down         1 = count up, 0 = count down
//   mode            00 wrap, 01 saturate, 10 one-shot, 11 wrap
//   clr_ovf         clears the sticky overflow flag
//   count           registered count value
//   c_out           carry/borrow out for the next-higher stage
//   tc              count sits at the terminal value for the current direction
//   ovf             sticky overflow/underflow flag
//   halted          one-shot run has finished
interface param_updown_counter_if #(
  parameter int unsigned WIDTH = 8
);
  logic             load;
  logic [WIDTH-1:0] load_in;
  logic             enable;
  logic             up_down;
  logic [1:0]       mode;
  logic             clr_ovf;
  logic [WIDTH-1:0] count;
  logic             c_out;
  logic             tc;
  logic             ovf;
  logic             halted;

  // Side that drives the controls and observes status (bench or parent block).
  modport master (
    output load, load_in, enable, up_down, mode, clr_ovf,
    input  count, c_out, tc, ovf, halted
  );

  // Counter side.
  modport slave (
    input  load, load_in, enable, up_down, mode, clr_ovf,
    output count, c_out, tc, ovf, halted
  );
endinterface

// File: rtl/param_updown_counter.sv
// Purpose: parameterised up/down counter with wrap, saturate and one-shot terminal behaviour, cascadable.
// Latency: count steps one clk after enable; tc and c_out are combinational in the same cycle.
// Backpressure: none; every enabled edge steps unless load, reset or a finished one-shot overrides it.
//
// Ports:
//   clk     single clock, all state changes on its rising edge
//   reset   synchronous active-high reset (count=0, ovf=0, halted=0)
//   bus     param_updown_counter_if.slave: load/load_in/enable/up_down/mode/clr_ovf in,
//           count/c_out/tc/ovf/halted out
module param_updown_counter #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] MAX_VALUE = {WIDTH{1'b1}}
) (
  input  logic                  clk,
  input  logic                  reset,
  param_updown_counter_if.slave bus
);

  // Elaboration-time guard on the legal parameter range.
  if (WIDTH < 2 || WIDTH > 32) begin : g_width_chk
    $error("param_updown_counter: WIDTH must be in 2..32");
  end
  if (MAX_VALUE == '0) begin : g_max_chk
    $error("param_updown_counter: MAX_VALUE must be at least 1");
  end

  typedef enum logic [1:0] {
    MODE_WRAP     = 2'b00,
    MODE_SAT      = 2'b01,
    MODE_ONESHOT  = 2'b10,
    MODE_WRAP_ALT = 2'b11
  } mode_t;

  // Run/halt control: HALTED is entered only by a one-shot terminal step and
  // left only by load (or reset).
  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             ovf_q;
  logic             ovf_d;
  state_t           state_q;
  state_t           state_d;

  mode_t            mode_in;
  logic [WIDTH-1:0] terminal;
  logic [WIDTH-1:0] load_val;
  logic             tc;
  logic             step;
  logic             c_out;

  assign mode_in  = mode_t'(bus.mode);

  // Terminal value follows up_down combinationally, so a direction change
  // retargets tc in the same cycle.
  assign terminal = bus.up_down ? MAX_VALUE : ZERO;
  assign tc       = (count_q == terminal);

  // A step happens only when no load is pending and the one-shot is not spent.
  assign step     = bus.enable && !bus.load && (state_q == ST_RUN);

  // Carry/borrow is purely combinational so chained stages advance on the
  // same edge as the stage below them.
  assign c_out    = tc && step;

  // Loads are clamped so count can never sit above MAX_VALUE.
  assign load_val = (bus.load_in > MAX_VALUE) ? MAX_VALUE : bus.load_in;

  // Count datapath: load > step > hold (reset is applied in the register).
  always_comb begin
    count_d = count_q;
    if (bus.load) begin
      count_d = load_val;
    end else if (step) begin
      if (!tc) begin
        count_d = bus.up_down ? (count_q + ONE) : (count_q - ONE);
      end else begin
        unique case (mode_in)
          MODE_WRAP, MODE_WRAP_ALT: count_d = bus.up_down ? ZERO : MAX_VALUE;
          MODE_SAT:                 count_d = count_q;
          MODE_ONESHOT:             count_d = count_q;
        endcase
      end
    end
  end

  // Run/halt next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (step && tc && (mode_in == MODE_ONESHOT)) begin
          state_d = ST_HALTED;
        end
      end
      ST_HALTED: begin
        if (bus.load) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Sticky overflow: a carry/borrow on the same edge as clr_ovf wins, so no
  // event is lost to a late clear.
  always_comb begin
    ovf_d = ovf_q;
    if (c_out) begin
      ovf_d = 1'b1;
    end else if (bus.clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= ZERO;
      ovf_q   <= 1'b0;
      state_q <= ST_RUN;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      state_q <= state_d;
    end
  end

  assign bus.count  = count_q;
  assign bus.tc     = tc;
  assign bus.c_out  = c_out;
  assign bus.ovf    = ovf_q;
  assign bus.halted = (state_q == ST_HALTED);

endmodule
